multicycle_mem_resp: RTL and testbench

Memory-side responder for the multi-cycle CPU controller's memory strobes (`MemRead`, `MemWrite`). It owns a word-organised data/instruction RAM. It serves one access at a time with a configurable wait latency, and returns a one-cycle `ready` pulse plus read data. The datapath stalls its controller state on `busy`. It sits between the controller/datapath address mux (`IorD`) and the storage array.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_array.sv | 27 ++
 rtl/multicycle_mem_resp.sv | 116 +++++++++++
 tb/tb_multicycle_mem_resp.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg: shared state/op encodings and the address fault check for the memory responder.
// Rev 1.0
package mem_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // The full word address is compared, so aliases above the array are rejected.
    function automatic logic addr_fault(input logic [31:0] a, input int unsigned depth);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// mem_array: single-port word RAM, synchronous write and asynchronous read by index.
// Rev 1.0
module mem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    // Contents are intentionally never reset so the array can map to block RAM.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule
`default_nettype wire

// File: rtl/multicycle_mem_resp.sv
`default_nettype none
// multicycle_mem_resp: serves one MemRead/MemWrite access at a time after LATENCY cycles.
// Rev 1.0
module multicycle_mem_resp
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          op_q, op_d;
    logic          fault_q, fault_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   arr_rdata;
    logic          arr_we;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (arr_we),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign arr_we = (state_q == RESP) && (op_q == OP_WR) && !fault_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fault_d = fault_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    op_d    = MemWrite ? OP_WR : OP_RD;
                    fault_d = addr_fault(addr, DEPTH);
                    idx_d   = addr[AW+1:2];
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (CNT_INIT != 4'd0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = DONE;
                if (op_q == OP_RD) begin
                    rdata_d = fault_q ? 32'h0 : arr_rdata;
                end
            end
            DONE: begin
                // A held strobe must not start a second access.
                if (!MemRead && !MemWrite) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_RD;
            fault_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fault_q <= fault_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // rdata_d equals the hold register except in a read RESP, where it is the live word.
    assign rdata = rdata_d;
    assign ready = (state_q == RESP);
    assign err   = (state_q == RESP) && fault_q;
    assign busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_mem_resp.sv
`default_nettype none
// tb_multicycle_mem_resp: three responders (LATENCY 2, 1, 15) on shared stimulus vs a timing/memory model.
// Rev 1.0
module tb_multicycle_mem_resp;

    localparam int unsigned DEPTH = 256;
    localparam int          NDUT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_w [NDUT];
    logic        ready_w [NDUT];
    logic        busy_w  [NDUT];
    logic        err_w   [NDUT];

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_hold [NDUT];

    always #5 clk = ~clk;

    multicycle_mem_resp #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[0]), .ready(ready_w[0]), .busy(busy_w[0]), .err(err_w[0]));
    multicycle_mem_resp #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[1]), .ready(ready_w[1]), .busy(busy_w[1]), .err(err_w[1]));
    multicycle_mem_resp #(.DEPTH(DEPTH), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[2]), .ready(ready_w[2]), .busy(busy_w[2]), .err(err_w[2]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Edge n=0 is the capture edge; strobes drop after edge n=hold.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input int extra);
        int          hold;
        int          lat;
        bit          flt;
        logic [31:0] new_rd;
        hold   = 16 + extra;
        flt    = is_fault(a);
        new_rd = 32'h0;
        if (!wr && !flt && ref_mem.exists(int'(a))) new_rd = ref_mem[int'(a)];
        @(negedge clk);
        MemRead = rd; MemWrite = wr; addr = a; wdata = d;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("idle_busy[%0d] a=%h", k, a), 32'(busy_w[k]), 32'd0);
            chk($sformatf("idle_ready[%0d] a=%h", k, a), 32'(ready_w[k]), 32'd0);
        end
        for (int n = 0; n <= hold + 2; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                lat = lat_of(k);
                if (n == lat - 1 && !wr) exp_hold[k] = new_rd;
                chk($sformatf("ready[%0d] a=%h n=%0d", k, a, n), 32'(ready_w[k]), 32'(n == lat - 1));
                chk($sformatf("err[%0d] a=%h n=%0d", k, a, n), 32'(err_w[k]), 32'(n == lat - 1 && flt));
                chk($sformatf("busy[%0d] a=%h n=%0d", k, a, n), 32'(busy_w[k]), 32'(n <= hold));
                chk($sformatf("rdata[%0d] a=%h n=%0d", k, a, n), rdata_w[k], exp_hold[k]);
            end
            if (n == 0) begin
                addr  = $urandom;
                wdata = $urandom;
            end
            if (n == hold) begin
                MemRead = 1'b0; MemWrite = 1'b0;
            end
        end
        if (wr && !flt) ref_mem[int'(a)] = d;
    endtask

    task automatic reset_mid_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("busy_pre_rst[%0d]", k), 32'(busy_w[k]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            exp_hold[k] = 32'h0;
            chk($sformatf("rst_ready[%0d]", k), 32'(ready_w[k]), 32'd0);
            chk($sformatf("rst_busy[%0d]", k), 32'(busy_w[k]), 32'd0);
            chk($sformatf("rst_err[%0d]", k), 32'(err_w[k]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", k), rdata_w[k], 32'h0);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic        wr;
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = 32'h0; wdata = 32'h0;
        for (int k = 0; k < NDUT; k++) exp_hold[k] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset_ready[%0d]", k), 32'(ready_w[k]), 32'd0);
            chk($sformatf("reset_busy[%0d]", k), 32'(busy_w[k]), 32'd0);
            chk($sformatf("reset_err[%0d]", k), 32'(err_w[k]), 32'd0);
            chk($sformatf("reset_rdata[%0d]", k), rdata_w[k], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 0);
        do_access(1'b1, 1'b1, 32'h20, 32'h12345678, 0);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 0);
        do_access(1'b1, 1'b0, 32'h22, 32'h0, 0);
        do_access(1'b1, 1'b0, 32'h400, 32'h0, 0);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 0);
        do_access(1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 0);
        do_access(1'b1, 1'b0, 32'h3FC, 32'h0, 0);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 6);
        do_access(1'b0, 1'b1, 32'h30, 32'h11223344, 0);
        reset_mid_write(32'h30, 32'hA5A5A5A5);
        do_access(1'b1, 1'b0, 32'h30, 32'h0, 0);

        for (int i = 0; i < 14; i++) begin
            a  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            wr = !ref_mem.exists(int'(a)) || ($urandom % 2 == 1);
            if (i % 5 == 4) begin
                a  = ($urandom % 2 == 1) ? (a + 32'($urandom_range(1, 3))) : (32'h400 + 32'($urandom_range(0, 255)));
                wr = 1'b0;
            end
            do_access(wr ? 1'($urandom % 2) : 1'b1, wr, a, $urandom, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
